// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM sample sequencer: FSM encoding, bit-length limits and clamp.
`default_nettype none

package pwm_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SERVE = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   localparam logic [5:0] BL_MIN = 6'd1;
   localparam logic [5:0] BL_MAX = 6'd16;

   // Clocks from a sampled req to mod_data_ready. Fixed at 1: the FIFO head is read
   // combinationally, so SERVE is never entered (it only exists for a registered-read variant).
   localparam int SERVE_LATENCY = 1;

   function automatic logic [5:0] clamp_bl(input logic [5:0] bl);
      if (bl < BL_MIN)
         return BL_MIN;
      else if (bl > BL_MAX)
         return BL_MAX;
      else
         return bl;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and occupancy counter.
`default_nettype none

module sync_fifo #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   // A push into a full FIFO is refused even when a pop happens on the same edge.
   assign full     = (level == (AW+1)'(DEPTH));
   assign empty    = (level == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

endmodule

`default_nettype wire

// File: rtl/pwm_sample_sequencer.sv
// Feeds one host-buffered duty sample per PWM period to the modulator via a 4-phase handshake.
`default_nettype none

module pwm_sample_sequencer
   import pwm_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic                     cfg_enable,
   input  logic [5:0]               cfg_bit_length,
   input  logic                     cfg_underflow_zero,
   input  logic                     req,
   output logic [DATA_W-1:0]        mod_data,
   output logic                     mod_data_ready,
   output logic [5:0]               mod_bit_length,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [15:0]              underflow_count
);

   localparam logic [1:0] SERVE_NEXT = (SERVE_LATENCY == 1) ? HOLD : SERVE;

   logic [1:0]        state;
   logic [DATA_W-1:0] last_sample;
   logic [DATA_W-1:0] head;
   logic              full;
   logic              empty;
   logic              fire;
   logic              pop;
   logic              underflow;
   logic [DATA_W-1:0] sel;
   logic [5:0]        bl_sel;
   logic [DATA_W:0]   limit;
   logic [DATA_W-1:0] served;

   sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (wr_valid),
      .push_data (wr_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .level     (fifo_level)
   );

   assign wr_ready  = !full;
   assign fire      = (state == IDLE) && req;
   // A same-edge push into an empty FIFO is not bypassed: it still counts as underflow.
   assign pop       = fire && cfg_enable && !empty;
   assign underflow = fire && cfg_enable && empty;
   assign bl_sel    = clamp_bl(cfg_bit_length);
   assign limit     = (DATA_W+1)'(1) << bl_sel;

   always_comb begin
      sel = '0;
      if (cfg_enable) begin
         if (!empty)
            sel = head;
         else if (!cfg_underflow_zero)
            sel = last_sample;
      end
   end

   // Duty above 2^bl is saturated to a full-on period.
   assign served = ({1'b0, sel} > limit) ? limit[DATA_W-1:0] : sel;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         mod_data        <= '0;
         mod_data_ready  <= 1'b0;
         mod_bit_length  <= BL_MIN;
         last_sample     <= '0;
         underflow_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fire) begin
                  mod_data       <= served;
                  mod_bit_length <= bl_sel;
                  mod_data_ready <= 1'b1;
                  last_sample    <= served;
                  state          <= SERVE_NEXT;
                  if (underflow && (underflow_count != 16'hFFFF))
                     underflow_count <= underflow_count + 16'd1;
               end
            end
            SERVE: begin
               state <= HOLD;
            end
            HOLD: begin
               if (!req) begin
                  mod_data_ready <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: begin
               state          <= IDLE;
               mod_data_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pwm_sample_sequencer.sv
// Directed scoreboard bench for pwm_sample_sequencer with immediate-assertion checks.
`default_nettype none

module tb_pwm_sample_sequencer;

   localparam int DEPTH  = 8;
   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DATA_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_ready;
   logic              cfg_enable;
   logic [5:0]        cfg_bit_length;
   logic              cfg_underflow_zero;
   logic              req;
   logic [DATA_W-1:0] mod_data;
   logic              mod_data_ready;
   logic [5:0]        mod_bit_length;
   logic [3:0]        fifo_level;
   logic [15:0]       underflow_count;

   int checks = 0;
   int errors = 0;

   int mq[$];          // model FIFO contents
   int sb[$];          // expected served (data<<8 | bl)
   int m_last = 0;
   int m_count = 0;

   always #5 clk = ~clk;

   pwm_sample_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .wr_data            (wr_data),
      .wr_valid           (wr_valid),
      .wr_ready           (wr_ready),
      .cfg_enable         (cfg_enable),
      .cfg_bit_length     (cfg_bit_length),
      .cfg_underflow_zero (cfg_underflow_zero),
      .req                (req),
      .mod_data           (mod_data),
      .mod_data_ready     (mod_data_ready),
      .mod_bit_length     (mod_bit_length),
      .fifo_level         (fifo_level),
      .underflow_count    (underflow_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_bl(input int c);
      if (c == 0) return 1;
      if (c > 16) return 16;
      return c;
   endfunction

   task automatic push(input int v);
      @(negedge clk);
      check("wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
      wr_data  = DATA_W'(v);
      wr_valid = 1'b1;
      if (mq.size() < DEPTH) mq.push_back(v);
      @(posedge clk);
      #1 wr_valid = 1'b0;
   endtask

   // Raise req (optionally with a same-edge push), check the served sample, hold req for
   // hold_cycles extra cycles, then drop req unless keep_high is set.
   task automatic serve(input bit do_push, input int v, input int hold_cycles, input bit keep_high);
      int val, bl, pre_size, exp_entry, got;
      bit seen;
      @(negedge clk);
      req = 1'b1;
      if (do_push) begin
         wr_data  = DATA_W'(v);
         wr_valid = 1'b1;
      end
      pre_size = mq.size();
      bl = exp_bl(int'(cfg_bit_length));
      if (!cfg_enable) val = 0;
      else if (pre_size > 0) val = mq.pop_front();
      else begin
         val = cfg_underflow_zero ? 0 : m_last;
         if (m_count < 65535) m_count++;
      end
      if (val > (1 << bl)) val = 1 << bl;
      m_last = val;
      if (do_push && pre_size < DEPTH) mq.push_back(v);
      sb.push_back((val << 8) | bl);
      @(posedge clk);
      #1 wr_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (mod_data_ready === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      check("ready_rise", 32'(seen), 32'd1);
      exp_entry = sb.pop_front();
      got = (int'(mod_data) << 8) | int'(mod_bit_length);
      check("served_data", 32'(mod_data), 32'(exp_entry >> 8));
      check("served_bl", 32'(mod_bit_length), 32'(exp_entry & 8'hFF));
      check("level_after_serve", 32'(fifo_level), 32'(mq.size()));
      check("uflow_count", 32'(underflow_count), 32'(m_count));
      for (int i = 0; i < hold_cycles; i++) begin
         @(negedge clk);
         check("hold_ready", 32'(mod_data_ready), 32'd1);
         check("hold_data", 32'((int'(mod_data) << 8) | int'(mod_bit_length)), 32'(got));
         check("hold_level", 32'(fifo_level), 32'(mq.size()));
      end
      if (!keep_high) begin
         @(negedge clk);
         req = 1'b0;
         @(posedge clk);
         #1 check("ready_fall", 32'(mod_data_ready), 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      wr_data = '0;
      wr_valid = 1'b0;
      cfg_enable = 1'b1;
      cfg_bit_length = 6'd10;
      cfg_underflow_zero = 1'b0;
      req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(mod_data_ready), 32'd0);
      check("rst_data", 32'(mod_data), 32'd0);
      check("rst_bl", 32'(mod_bit_length), 32'd1);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_wr_ready", 32'(wr_ready), 32'd1);
      rst_n = 1'b1;

      // In-order service with bl=10 (2^10 keeps 300 unclamped).
      push(100); push(200); push(300);
      @(negedge clk) check("level3", 32'(fifo_level), 32'd3);
      for (int i = 0; i < 3; i++) serve(1'b0, 0, 0, 1'b0);

      // Underflow: repeat last, then zero.
      serve(1'b0, 0, 0, 1'b0);
      cfg_underflow_zero = 1'b1;
      serve(1'b0, 0, 0, 1'b0);

      // Fill past capacity, then serve with a rejected same-edge push.
      cfg_bit_length = 6'd16;
      for (int i = 0; i < DEPTH + 2; i++) push(1000 + i);
      @(negedge clk);
      check("full_level", 32'(fifo_level), 32'(DEPTH));
      check("full_wr_ready", 32'(wr_ready), 32'd0);
      serve(1'b1, 9999, 0, 1'b0);

      // Long hold: no second pop, stable outputs.
      serve(1'b0, 0, 10, 1'b0);

      // Disabled: zero duty, no pop, no count.
      cfg_enable = 1'b0;
      serve(1'b0, 0, 0, 1'b0);
      cfg_enable = 1'b1;
      for (int i = 0; i < 6; i++) serve(1'b0, 0, 0, 1'b0);

      // Bit-length clamps and duty clamp.
      push(1);     cfg_bit_length = 6'd0;  serve(1'b0, 0, 0, 1'b0);
      push(50000); cfg_bit_length = 6'd40; serve(1'b0, 0, 0, 1'b0);
      push(1000);  cfg_bit_length = 6'd4;  serve(1'b0, 0, 0, 1'b0);

      // Empty FIFO with same-edge push: underflow, pushed sample served next.
      cfg_bit_length = 6'd16;
      serve(1'b1, 777, 0, 1'b0);
      serve(1'b0, 0, 0, 1'b0);

      // Reset during HOLD with samples queued.
      for (int i = 0; i < 5; i++) push(10 + i);
      serve(1'b0, 0, 2, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("hrst_ready", 32'(mod_data_ready), 32'd0);
      check("hrst_level", 32'(fifo_level), 32'd0);
      check("hrst_count", 32'(underflow_count), 32'd0);
      check("hrst_data", 32'(mod_data), 32'd0);
      mq.delete();
      sb.delete();
      m_last = 0;
      m_count = 0;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cfg_underflow_zero = 1'b0;
      serve(1'b0, 0, 0, 1'b0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
